// File: rtl/player_motion_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : player_motion_ctl_pkg
// Description : Shared game types and default physics constants used by the
//               player draw and motion-control blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package player_motion_ctl_pkg;

    typedef logic [1:0] player_state_t;

    localparam player_state_t ST_IDLE   = 2'd0;
    localparam player_state_t ST_WALK_L = 2'd1;
    localparam player_state_t ST_WALK_R = 2'd2;
    localparam player_state_t ST_AIR    = 2'd3;

    localparam int c_def_n_players = 2;
    localparam int c_def_x_max     = 800;
    localparam int c_def_y_floor   = 500;
    localparam int c_def_player_w  = 32;
    localparam int c_def_step      = 4;
    localparam int c_def_jump_v    = 16;
    localparam int c_def_gravity   = 1;
    localparam int c_def_x_start   = 100;
    localparam int c_def_x_spacing = 500;

    // Grounded state implied by the horizontal request pair.
    function automatic player_state_t walk_state(input logic left, input logic right);
        if (left && !right)
            return ST_WALK_L;
        else if (right && !left)
            return ST_WALK_R;
        else
            return ST_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_motion_ctl_axis.sv
`default_nettype none
// ============================================================================
// Module      : player_axis
// Description : Motion state of a single player: horizontal walking with
//               edge clamps, jump ballistics with floor and ceiling limits.
// Revision    : 1.0 - initial release
// ============================================================================
module player_axis
    import player_motion_ctl_pkg::*;
#(
    parameter int X_MAX    = c_def_x_max,
    parameter int Y_FLOOR  = c_def_y_floor,
    parameter int PLAYER_W = c_def_player_w,
    parameter int STEP     = c_def_step,
    parameter int JUMP_V   = c_def_jump_v,
    parameter int GRAVITY  = c_def_gravity,
    parameter int X_RESET  = c_def_x_start
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_update,
    input  logic          i_left,
    input  logic          i_right,
    input  logic          i_jump,
    output logic [11:0]   o_xpos,
    output logic [11:0]   o_ypos,
    output player_state_t o_state
);

    localparam logic signed [12:0] c_step     = 13'(STEP);
    localparam logic signed [12:0] c_x_lim    = 13'(X_MAX - PLAYER_W);
    localparam logic        [11:0] c_x_lim_u  = 12'(X_MAX - PLAYER_W);
    localparam logic signed [12:0] c_y_floor  = 13'(Y_FLOOR);
    localparam logic        [11:0] c_y_floor_u = 12'(Y_FLOOR);
    localparam logic        [11:0] c_y_jump   = 12'(Y_FLOOR - JUMP_V);
    localparam logic signed [7:0]  c_vy_jump  = 8'(JUMP_V - GRAVITY);
    localparam logic signed [8:0]  c_grav     = 9'(GRAVITY);
    localparam logic        [11:0] c_x_reset  = 12'(X_RESET);

    logic        [11:0] r_x;
    logic        [11:0] r_y;
    logic signed [7:0]  r_vy;
    player_state_t      r_state;

    logic        [11:0] w_x_next;
    logic        [11:0] w_y_next;
    logic signed [7:0]  w_vy_next;
    player_state_t      w_state_next;
    logic signed [12:0] w_x_dec;
    logic signed [12:0] w_x_inc;
    logic signed [12:0] w_y_air;
    logic signed [8:0]  w_vy_air;
    logic               w_left_only;
    logic               w_right_only;
    logic               w_grounded;

    always_comb begin
        w_left_only  = i_left & ~i_right;
        w_right_only = i_right & ~i_left;
        w_grounded   = (r_state != ST_AIR);

        w_x_dec  = $signed({1'b0, r_x}) - c_step;
        w_x_inc  = $signed({1'b0, r_x}) + c_step;
        w_y_air  = $signed({1'b0, r_y}) - $signed({{5{r_vy[7]}}, r_vy});
        w_vy_air = $signed({r_vy[7], r_vy}) - c_grav;

        w_x_next     = r_x;
        w_y_next     = r_y;
        w_vy_next    = r_vy;
        w_state_next = r_state;

        if (w_left_only)
            w_x_next = (w_x_dec < 13'sd0) ? 12'd0 : w_x_dec[11:0];
        else if (w_right_only)
            w_x_next = (w_x_inc > c_x_lim) ? c_x_lim_u : w_x_inc[11:0];

        if (w_grounded) begin
            if (i_jump && (r_y == c_y_floor_u)) begin
                w_y_next     = c_y_jump;
                w_vy_next    = c_vy_jump;
                w_state_next = ST_AIR;
            end else begin
                w_state_next = walk_state(i_left, i_right);
            end
        end else begin
            // Saturate vy rather than let a long fall wrap to an upward speed.
            w_vy_next = (w_vy_air < -9'sd128) ? 8'sh80 : w_vy_air[7:0];
            if (w_y_air >= c_y_floor) begin
                w_y_next     = c_y_floor_u;
                w_vy_next    = 8'sd0;
                w_state_next = walk_state(i_left, i_right);
            end else if (w_y_air < 13'sd0) begin
                w_y_next  = 12'd0;
                w_vy_next = 8'sd0;
            end else begin
                w_y_next = w_y_air[11:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= c_x_reset;
            r_y     <= c_y_floor_u;
            r_vy    <= 8'sd0;
            r_state <= ST_IDLE;
        end else if (i_update) begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_vy    <= w_vy_next;
            r_state <= w_state_next;
        end
    end

    assign o_xpos  = r_x;
    assign o_ypos  = r_y;
    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/player_motion_ctl.sv
`default_nettype none
// ============================================================================
// Module      : player_motion_ctl
// Description : Frame-rate motion controller for N_PLAYERS independent
//               players; one update per rising edge of vsync.
// Revision    : 1.0 - initial release
// ============================================================================
module player_motion_ctl
    import player_motion_ctl_pkg::*;
#(
    parameter int N_PLAYERS = c_def_n_players,
    parameter int X_MAX     = c_def_x_max,
    parameter int Y_FLOOR   = c_def_y_floor,
    parameter int PLAYER_W  = c_def_player_w,
    parameter int STEP      = c_def_step,
    parameter int JUMP_V    = c_def_jump_v,
    parameter int GRAVITY   = c_def_gravity,
    parameter int X_START   = c_def_x_start,
    parameter int X_SPACING = c_def_x_spacing
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               v_tick,
    input  logic                               freeze,
    input  logic          [N_PLAYERS-1:0]       move_left,
    input  logic          [N_PLAYERS-1:0]       move_right,
    input  logic          [N_PLAYERS-1:0]       jump,
    output logic          [N_PLAYERS-1:0][11:0] xpos,
    output logic          [N_PLAYERS-1:0][11:0] ypos,
    output player_state_t [N_PLAYERS-1:0]       state
);

    logic r_v_tick_d;
    logic w_frame_tick;
    logic w_update;

    always_ff @(posedge clk) begin
        if (rst)
            r_v_tick_d <= 1'b0;
        else
            r_v_tick_d <= v_tick;
    end

    assign w_frame_tick = v_tick & ~r_v_tick_d;
    assign w_update     = w_frame_tick & ~freeze;

    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
            player_axis #(
                .X_MAX    (X_MAX),
                .Y_FLOOR  (Y_FLOOR),
                .PLAYER_W (PLAYER_W),
                .STEP     (STEP),
                .JUMP_V   (JUMP_V),
                .GRAVITY  (GRAVITY),
                .X_RESET  (X_START + gi * X_SPACING)
            ) u_axis (
                .clk      (clk),
                .rst      (rst),
                .i_update (w_update),
                .i_left   (move_left[gi]),
                .i_right  (move_right[gi]),
                .i_jump   (jump[gi]),
                .o_xpos   (xpos[gi]),
                .o_ypos   (ypos[gi]),
                .o_state  (state[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_motion_ctl
// Description : Self-checking bench for player_motion_ctl with default
//               parameters and two players.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion_ctl;
    import player_motion_ctl_pkg::*;

    localparam int NP = 2;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic                         v_tick = 1'b0;
    logic                         freeze = 1'b0;
    logic          [NP-1:0]       move_left = '0;
    logic          [NP-1:0]       move_right = '0;
    logic          [NP-1:0]       jump = '0;
    logic          [NP-1:0][11:0] xpos;
    logic          [NP-1:0][11:0] ypos;
    player_state_t [NP-1:0]       state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, plain integers.
    int mx [NP];
    int my [NP];
    int mvy[NP];
    int mst[NP];

    player_motion_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .v_tick     (v_tick),
        .freeze     (freeze),
        .move_left  (move_left),
        .move_right (move_right),
        .jump       (jump),
        .xpos       (xpos),
        .ypos       (ypos),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ml;
        logic [1:0] mr;
        logic [1:0] jp;
        logic       frz;
        int         nfr;
        int         ex0;
        int         ex1;
        int         ey0;
        int         ey1;
        int         es0;
        int         es1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NP; i++) begin
            mx[i]  = 100 + i * 500;
            my[i]  = 500;
            mvy[i] = 0;
            mst[i] = 0;
        end
    endtask

    // One frame: vsync high for two clocks, low for two; sampled at negedges.
    task automatic do_frame();
        @(negedge clk);
        v_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        v_tick = 1'b0;
        @(negedge clk);
    endtask

    function automatic int walk_of(input bit l, input bit r);
        if (l && !r) return 1;
        if (r && !l) return 2;
        return 0;
    endfunction

    task automatic model_step(input int i, input bit l, input bit r, input bit j);
        int yn;
        if (l && !r) mx[i] = (mx[i] - 4 < 0) ? 0 : mx[i] - 4;
        if (r && !l) mx[i] = (mx[i] + 4 > 768) ? 768 : mx[i] + 4;
        if (mst[i] != 3) begin
            if (j && my[i] == 500) begin
                my[i] = 484; mvy[i] = 15; mst[i] = 3;
            end else begin
                mst[i] = walk_of(l, r);
            end
        end else begin
            yn = my[i] - mvy[i];
            mvy[i] = mvy[i] - 1;
            if (yn >= 500) begin
                my[i] = 500; mvy[i] = 0; mst[i] = walk_of(l, r);
            end else if (yn < 0) begin
                my[i] = 0; mvy[i] = 0;
            end else begin
                my[i] = yn;
            end
        end
    endtask

    task automatic check_model(input int k);
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("rnd%0d_x%0d", k, i), int'(xpos[i]), mx[i]);
            chk($sformatf("rnd%0d_y%0d", k, i), int'(ypos[i]), my[i]);
            chk($sformatf("rnd%0d_st%0d", k, i), int'(state[i]), mst[i]);
        end
    endtask

    initial begin
        //               ml     mr     jp     frz  nfr  x0   x1   y0   y1   s0 s1
        vecs[0] = '{2'b00, 2'b01, 2'b00, 1'b0, 3,   112, 600, 500, 500, 2, 0};
        vecs[1] = '{2'b00, 2'b10, 2'b00, 1'b0, 100, 112, 768, 500, 500, 0, 2};
        vecs[2] = '{2'b01, 2'b00, 2'b00, 1'b0, 30,  0,   768, 500, 500, 1, 0};
        vecs[3] = '{2'b01, 2'b01, 2'b00, 1'b0, 2,   0,   768, 500, 500, 0, 0};
        vecs[4] = '{2'b11, 2'b00, 2'b11, 1'b1, 5,   0,   768, 500, 500, 0, 0};
        vecs[5] = '{2'b00, 2'b00, 2'b01, 1'b0, 1,   0,   768, 484, 500, 3, 0};
        vecs[6] = '{2'b00, 2'b00, 2'b01, 1'b0, 15,  0,   768, 364, 500, 3, 0};
        vecs[7] = '{2'b00, 2'b00, 2'b00, 1'b0, 17,  0,   768, 500, 500, 0, 0};

        do_reset();
        chk("rst_x0", int'(xpos[0]), 100);
        chk("rst_x1", int'(xpos[1]), 600);
        chk("rst_y0", int'(ypos[0]), 500);
        chk("rst_y1", int'(ypos[1]), 500);
        chk("rst_st0", int'(state[0]), int'(ST_IDLE));
        chk("rst_st1", int'(state[1]), int'(ST_IDLE));

        for (int v = 0; v < 8; v++) begin
            move_left  = vecs[v].ml;
            move_right = vecs[v].mr;
            jump       = vecs[v].jp;
            freeze     = vecs[v].frz;
            for (int f = 0; f < vecs[v].nfr; f++) do_frame();
            chk($sformatf("vec%0d_x0", v), int'(xpos[0]), vecs[v].ex0);
            chk($sformatf("vec%0d_x1", v), int'(xpos[1]), vecs[v].ex1);
            chk($sformatf("vec%0d_y0", v), int'(ypos[0]), vecs[v].ey0);
            chk($sformatf("vec%0d_y1", v), int'(ypos[1]), vecs[v].ey1);
            chk($sformatf("vec%0d_st0", v), int'(state[0]), vecs[v].es0);
            chk($sformatf("vec%0d_st1", v), int'(state[1]), vecs[v].es1);
        end
        move_left = '0; move_right = '0; jump = '0; freeze = 1'b0;

        // Update lands exactly one edge after vsync rises, and only once per rise.
        do_reset();
        @(negedge clk);
        move_right = 2'b01;
        v_tick = 1'b1;
        #1;
        chk("lat_before", int'(xpos[0]), 100);
        @(negedge clk);
        chk("lat_after", int'(xpos[0]), 104);
        repeat (3) @(negedge clk);
        chk("lat_hold", int'(xpos[0]), 104);
        v_tick = 1'b0;
        move_right = '0;
        @(negedge clk);

        // Reset mid-jump overrides a coincident frame update.
        do_reset();
        jump = 2'b01;
        for (int f = 0; f < 20; f++) begin
            if (ypos[0] == 12'd400) break;
            do_frame();
        end
        chk("air_y0", int'(ypos[0]), 400);
        chk("air_st0", int'(state[0]), int'(ST_AIR));
        @(negedge clk);
        rst = 1'b1;
        v_tick = 1'b1;
        move_left = 2'b11;
        @(negedge clk);
        chk("midrst_x0", int'(xpos[0]), 100);
        chk("midrst_x1", int'(xpos[1]), 600);
        chk("midrst_y0", int'(ypos[0]), 500);
        chk("midrst_st0", int'(state[0]), int'(ST_IDLE));
        rst = 1'b0;
        v_tick = 1'b0;
        move_left = '0;
        jump = '0;

        // Randomized frames against the reference model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit frz;
            for (int i = 0; i < NP; i++) begin
                move_left[i]  = ($urandom_range(0, 2) == 0);
                move_right[i] = ($urandom_range(0, 2) == 0);
                jump[i]       = ($urandom_range(0, 5) == 0);
            end
            frz = ($urandom_range(0, 7) == 0);
            freeze = frz;
            do_frame();
            if (!frz)
                for (int i = 0; i < NP; i++)
                    model_step(i, move_left[i], move_right[i], jump[i]);
            check_model(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_motion_ctl.md
PLAYER_MOTION_CTL -- requirements
Module: player_motion_ctl

Interface
REQ-001 Parameter N_PLAYERS, default 2, number of independently controlled players (1..8).
REQ-002 Parameter X_MAX, default 800, visible width in pixels; Y_FLOOR, default 500, ground y of the player's top edge.
REQ-003 Parameter PLAYER_W, default 32, sprite width; STEP, default 4, horizontal pixels per frame.
REQ-004 Parameter JUMP_V, default 16, initial upward velocity; GRAVITY, default 1, velocity decrement per frame.
REQ-005 Parameter X_START, default 100, and X_SPACING, default 500; player i reset x = X_START + i*X_SPACING.
REQ-006 clk  in  1  single clock, 40 MHz pixel domain; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 v_tick  in  1  vsync from the timing generator; its rising edge marks a frame.
REQ-009 freeze  in  1  global hold; when high, no position or velocity update occurs.
REQ-010 move_left, move_right, jump  in  N_PLAYERS each  per-player level requests; bit i belongs to player i.
REQ-011 xpos, ypos  out  N_PLAYERS x 12  registered player top-left coordinates.
REQ-012 state  out  N_PLAYERS x player_state_t  registered per-player motion state.

Function
REQ-013 frame_tick SHALL be high for exactly one cycle when v_tick is sampled 1 after being sampled 0 (v_tick_d register).
REQ-014 Outputs SHALL change only at the clock edge following a frame_tick cycle (1-cycle latency), and only when freeze is 0 in that cycle.
REQ-015 States: ST_IDLE, ST_WALK_L, ST_WALK_R (grounded) and ST_AIR; state is re-evaluated every frame update.
REQ-016 Horizontal: left only -> x = max(x-STEP, 0); right only -> x = min(x+STEP, X_MAX-PLAYER_W); both or neither -> x unchanged.
REQ-017 Grounded state: left only -> ST_WALK_L, right only -> ST_WALK_R, otherwise ST_IDLE.
REQ-018 Jump: jump high while grounded (y == Y_FLOOR) -> y = Y_FLOOR-JUMP_V, vy = JUMP_V-GRAVITY, state ST_AIR; jump while in ST_AIR is ignored.
REQ-019 In ST_AIR each frame: y_next = y - vy, vy_next = vy - GRAVITY; horizontal moves still apply per REQ-016.
REQ-020 Landing: if y_next >= Y_FLOOR then y = Y_FLOOR, vy = 0, state per REQ-017 in that same update.
REQ-021 Ceiling: if y_next < 0 then y = 0, vy = 0, state remains ST_AIR.
REQ-022 Arithmetic: vy is 8-bit signed; y_next and x_next computed at 13-bit signed width before clamping; no wrap-around permitted.
REQ-023 Players SHALL be fully independent; simultaneous requests on all players are serviced in the same update.

Reset
REQ-024 On rst: x[i] = X_START + i*X_SPACING, y[i] = Y_FLOOR, vy[i] = 0, state[i] = ST_IDLE, v_tick_d = 0.
REQ-025 rst asserted mid-jump or mid-walk SHALL override any pending frame update in that cycle.

Structure
REQ-026 player_state_t and the default physics constants SHALL live in the shared game package used by the draw and control blocks.
REQ-027 Per-player motion SHALL be one sub-module, player_axis, instantiated N_PLAYERS times by a generate loop; frame-tick detection stays in the parent.

Verification (N_PLAYERS=2, defaults)
REQ-028 Reset -> x = {100,600}, y = {500,500}, state = {ST_IDLE,ST_IDLE}.
REQ-029 move_right[0] held for 3 frames -> x0 = 112, state0 = ST_WALK_R; player 1 unchanged at x1 = 600.
REQ-030 move_right[1] held for 100 frames -> x1 saturates at 768 and stays there; move_left[0] for 30 frames -> x0 = 0.
REQ-031 jump[0] for 1 frame -> y0 = 484 next update; apex y0 = 364 after 16 frames; y0 = 500, state0 = ST_IDLE after 33 frames; jump re-pressed in air has no effect.
REQ-032 move_left and move_right both high -> x unchanged, ST_IDLE; freeze high across 5 v_tick edges -> all outputs constant.
REQ-033 rst pulsed while player 0 is in ST_AIR at y0 = 400 -> reset values of REQ-024 on the following cycle.
